ipl_memory_arbiter: RTL

Two-master arbiter for the single-port 2048×32 IPL boot memory. It lets the CPU bus (port 0) and the boot loader/debug master (port 1) share the one RAM port. Fixed or round-robin arbitration, one access granted per cycle, pipelined reads with fixed latency 1. It sits between the system interconnect and the IPL memory's s1 port.

---
 rtl/ipl_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/ipl_memory_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ipl_arb_pkg.sv
// Shared widths and types for the two-master IPL boot-memory arbiter.
package ipl_arb_pkg;

    localparam int IPL_ADDR_W = 11;
    localparam int IPL_DATA_W = 32;
    localparam int IPL_BE_W   = 4;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_sel_t;

    typedef struct packed {
        logic [IPL_ADDR_W-1:0] address;
        logic [IPL_BE_W-1:0]   byteenable;
        logic [IPL_DATA_W-1:0] writedata;
        logic                  write;
    } ipl_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic: combinational grant, registered "last granted" pointer
// used to alternate under contention when rr_mode is set.
import ipl_arb_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rr_mode,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_sel_t last;

    always_comb begin
        gnt = 2'b00;
        if (reset_n) begin
            if (req == 2'b11) begin
                if (rr_mode && (last == PORT0))
                    gnt = 2'b10;
                else
                    gnt = 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to PORT1 so that port 0 wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)
            last <= PORT1;
        else if (gnt[0])
            last <= PORT0;
        else if (gnt[1])
            last <= PORT1;
    end

endmodule

// File: rtl/ipl_memory_arbiter.sv
// Shares the single-port IPL RAM between the CPU bus (port 0) and the boot/debug
// master (port 1); one access per cycle, reads return one cycle after acceptance.
import ipl_arb_pkg::*;

module ipl_memory_arbiter #(
    parameter int ADDR_W  = IPL_ADDR_W,
    parameter int DATA_W  = IPL_DATA_W,
    parameter int RR_MODE = 1,
    parameter int WP_INIT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    output logic                p0_waitrequest,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic                p0_readdatavalid,
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    output logic                p1_waitrequest,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic                p1_readdatavalid,
    input  logic                wp_set,
    input  logic                wp_clr,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    ipl_req_t            req0;
    ipl_req_t            req1;
    ipl_req_t            sel;
    logic                granted;
    logic                wp;
    logic                wp_block;
    logic                wp_violation;
    logic                rd_pend;
    port_sel_t           rd_owner;
    logic [ADDR_W-1:0]   held_address;
    logic [DATA_W/8-1:0] held_byteenable;
    logic [DATA_W-1:0]   held_writedata;

    assign req = {p1_read | p1_write, p0_read | p0_write};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .rr_mode (RR_MODE != 0),
        .req     (req),
        .gnt     (gnt)
    );

    assign req0 = '{address: p0_address, byteenable: p0_byteenable,
                    writedata: p0_writedata, write: p0_write};
    assign req1 = '{address: p1_address, byteenable: p1_byteenable,
                    writedata: p1_writedata, write: p1_write};
    assign sel     = gnt[1] ? req1 : req0;
    assign granted = |gnt;

    // A protected port-1 write is still accepted, it just never reaches the RAM.
    assign wp_block = gnt[1] & p1_write & wp;

    assign p0_waitrequest = ~gnt[0];
    assign p1_waitrequest = ~gnt[1];

    assign mem_address    = granted ? sel.address    : held_address;
    assign mem_byteenable = granted ? sel.byteenable : held_byteenable;
    assign mem_writedata  = granted ? sel.writedata  : held_writedata;
    assign mem_chipselect = granted & ~wp_block;
    assign mem_write      = granted & sel.write & ~wp_block;
    assign mem_clken      = reset_n;

    assign p0_readdata      = mem_readdata;
    assign p1_readdata      = mem_readdata;
    assign p0_readdatavalid = reset_n & rd_pend & (rd_owner == PORT0);
    assign p1_readdatavalid = reset_n & rd_pend & (rd_owner == PORT1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            held_address    <= '0;
            held_byteenable <= '0;
            held_writedata  <= '0;
        end else if (granted) begin
            held_address    <= sel.address;
            held_byteenable <= sel.byteenable;
            held_writedata  <= sel.writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp           <= (WP_INIT != 0);
            wp_violation <= 1'b0;
        end else begin
            if (wp_set)
                wp <= 1'b1;
            else if (wp_clr)
                wp <= 1'b0;
            wp_violation <= wp_violation | wp_block;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT0;
        end else begin
            rd_pend <= granted & ~sel.write;
            if (granted)
                rd_owner <= gnt[1] ? PORT1 : PORT0;
        end
    end

endmodule
